// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM extension arbiter: FSM state codes,
// read latency, requester-ID width and the command record.
package sram_arb_pkg;

   localparam int BW_DATA_DEF = 64;
   localparam int BW_ADDR_DEF = 6;

   // Cycles from command acceptance to read data on the response channel
   localparam int RD_LAT = 2;

   // Width of the owner tag carried alongside each read
   localparam int REQ_ID_W = 1;

   typedef logic [0:0] state_t;
   localparam state_t ST_INIT = 1'b0;
   localparam state_t ST_RUN  = 1'b1;

   typedef struct packed {
      logic                   we;
      logic [BW_ADDR_DEF-1:0] addr;
      logic [BW_DATA_DEF-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The last-grant pointer only moves when a
// grant is actually issued, so idle cycles never disturb fairness.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_valid,
   input  logic       i_en,
   output logic [1:0] o_gnt
);

   logic r_lastGnt;

   // Lone requester wins outright; on contention the one not served last wins
   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_valid == 2'b11) begin
            o_gnt = r_lastGnt ? 2'b01 : 2'b10;
         end else begin
            o_gnt = i_valid;
         end
      end
   end

   // Pointer starts at 1 so requester 0 wins the first contention
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lastGnt <= 1'b1;
      end else if (|o_gnt) begin
         r_lastGnt <= o_gnt[1];
      end
   end

endmodule

// File: rtl/sram_ext_arbiter.sv
// Round-robin arbiter and sequencer in front of the banked single-port SRAM
// extension. Accepts at most one command per cycle, drives the SRAM pins from
// registers, and routes read data back to its owner RD_LAT cycles later.
// Optional zero-fill engine after reset: define SRAM_ARB_INIT_EN.
module sram_ext_arbiter
   import sram_arb_pkg::*;
#(
   parameter int BW_DATA = BW_DATA_DEF,
   parameter int BW_ADDR = BW_ADDR_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic               i_req0_we,
   input  logic [BW_ADDR-1:0] i_req0_addr,
   input  logic [BW_DATA-1:0] i_req0_wdata,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic               i_req1_we,
   input  logic [BW_ADDR-1:0] i_req1_addr,
   input  logic [BW_DATA-1:0] i_req1_wdata,
   output logic               o_rsp0_valid,
   output logic [BW_DATA-1:0] o_rsp0_data,
   output logic               o_rsp1_valid,
   output logic [BW_DATA-1:0] o_rsp1_data,
   output logic               o_mem_cen,
   output logic               o_mem_wen,
   output logic               o_mem_oen,
   output logic [BW_ADDR-1:0] o_mem_addr,
   output logic [BW_DATA-1:0] o_mem_wdata,
   input  logic [BW_DATA-1:0] i_mem_rdata,
   output logic               o_busy
);

   logic                             w_inInit;
   logic [BW_ADDR-1:0]               w_initAddr;
   logic                             w_arbEn;
   logic [1:0]                       w_gnt;
   logic                             w_anyGnt;
   cmd_t                             w_selCmd;
   logic [REQ_ID_W-1:0]              w_rspOwner;
   logic                             w_rspValid;
   logic [RD_LAT-1:0]                r_rdPipe;
   logic [RD_LAT-1:0][REQ_ID_W-1:0]  r_ownPipe;

`ifdef SRAM_ARB_INIT_EN
   localparam logic [BW_ADDR-1:0] ADDR_ONE  = {{(BW_ADDR-1){1'b0}}, 1'b1};
   localparam logic [BW_ADDR-1:0] ADDR_LAST = {BW_ADDR{1'b1}};

   state_t             r_state;
   logic [BW_ADDR-1:0] r_initCnt;

   // Sweep every address once after reset; the counter wrap hands over to RUN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_INIT;
         r_initCnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_initCnt <= r_initCnt + ADDR_ONE;
         if (r_initCnt == ADDR_LAST) begin
            r_state <= ST_RUN;
         end
      end
   end

   assign w_inInit   = (r_state == ST_INIT);
   assign w_initAddr = r_initCnt;
`else
   assign w_inInit   = 1'b0;
   assign w_initAddr = '0;
`endif

   assign o_busy = w_inInit;

   // Requesters are locked out during zero-fill and while reset is held
   assign w_arbEn = ~w_inInit & ~i_rst;

   rr_arb2 u_rrArb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid ({i_req1_valid, i_req0_valid}),
      .i_en    (w_arbEn),
      .o_gnt   (w_gnt)
   );

   assign o_req0_ready = w_gnt[0];
   assign o_req1_ready = w_gnt[1];
   assign w_anyGnt     = |w_gnt;

   // Steer the winning requester's command towards the pin registers
   always_comb begin
      w_selCmd.we    = i_req0_we;
      w_selCmd.addr  = i_req0_addr;
      w_selCmd.wdata = i_req0_wdata;
      if (w_gnt[1]) begin
         w_selCmd.we    = i_req1_we;
         w_selCmd.addr  = i_req1_addr;
         w_selCmd.wdata = i_req1_wdata;
      end
   end

   // SRAM pins are always registered: zero-fill writes, granted commands, or idle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mem_cen   <= 1'b0;
         o_mem_wen   <= 1'b0;
         o_mem_oen   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else if (w_inInit) begin
         o_mem_cen   <= 1'b1;
         o_mem_wen   <= 1'b1;
         o_mem_oen   <= 1'b0;
         o_mem_addr  <= w_initAddr;
         o_mem_wdata <= '0;
      end else if (w_anyGnt) begin
         o_mem_cen   <= 1'b1;
         o_mem_wen   <= w_selCmd.we;
         o_mem_oen   <= ~w_selCmd.we;
         o_mem_addr  <= w_selCmd.addr;
         o_mem_wdata <= w_selCmd.wdata;
      end else begin
         o_mem_cen   <= 1'b0;
         o_mem_wen   <= 1'b0;
         o_mem_oen   <= 1'b0;
      end
   end

   // Read flag and owner tag ride alongside the SRAM access until data returns
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdPipe  <= '0;
         r_ownPipe <= '0;
      end else begin
         r_rdPipe  <= {r_rdPipe[RD_LAT-2:0], (w_anyGnt & ~w_selCmd.we)};
         r_ownPipe <= {r_ownPipe[RD_LAT-2:0], w_gnt[1]};
      end
   end

   assign w_rspValid  = r_rdPipe[RD_LAT-1];
   assign w_rspOwner  = r_ownPipe[RD_LAT-1];

   assign o_rsp0_valid = w_rspValid & (w_rspOwner == REQ_ID_W'(0));
   assign o_rsp1_valid = w_rspValid & (w_rspOwner == REQ_ID_W'(1));
   assign o_rsp0_data  = o_rsp0_valid ? i_mem_rdata : '0;
   assign o_rsp1_data  = o_rsp1_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_sram_ext_arbiter.sv
// Directed self-checking bench for sram_ext_arbiter with a behavioural
// registered-read SRAM attached to the pins. Covers the zero-fill path
// when SRAM_ARB_INIT_EN is defined.
module tb_sram_ext_arbiter;

   localparam logic [63:0] DATA_A = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] DATA_B = 64'h01234567_89ABCDEF;

   logic        i_clk;
   logic        i_rst;
   logic        i_req0_valid;
   logic        o_req0_ready;
   logic        i_req0_we;
   logic [5:0]  i_req0_addr;
   logic [63:0] i_req0_wdata;
   logic        i_req1_valid;
   logic        o_req1_ready;
   logic        i_req1_we;
   logic [5:0]  i_req1_addr;
   logic [63:0] i_req1_wdata;
   logic        o_rsp0_valid;
   logic [63:0] o_rsp0_data;
   logic        o_rsp1_valid;
   logic [63:0] o_rsp1_data;
   logic        o_mem_cen;
   logic        o_mem_wen;
   logic        o_mem_oen;
   logic [5:0]  o_mem_addr;
   logic [63:0] o_mem_wdata;
   logic [63:0] i_mem_rdata;
   logic        o_busy;

   logic [63:0] memArr [64];
   logic        fillMem;

   int checks;
   int failures;
   int acc0;
   int acc1;

   sram_ext_arbiter dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_req0_valid (i_req0_valid),
      .o_req0_ready (o_req0_ready),
      .i_req0_we    (i_req0_we),
      .i_req0_addr  (i_req0_addr),
      .i_req0_wdata (i_req0_wdata),
      .i_req1_valid (i_req1_valid),
      .o_req1_ready (o_req1_ready),
      .i_req1_we    (i_req1_we),
      .i_req1_addr  (i_req1_addr),
      .i_req1_wdata (i_req1_wdata),
      .o_rsp0_valid (o_rsp0_valid),
      .o_rsp0_data  (o_rsp0_data),
      .o_rsp1_valid (o_rsp1_valid),
      .o_rsp1_data  (o_rsp1_data),
      .o_mem_cen    (o_mem_cen),
      .o_mem_wen    (o_mem_wen),
      .o_mem_oen    (o_mem_oen),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .o_busy       (o_busy)
   );

   // Free-running 10 ns clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Behavioural SRAM: registered read, data valid the cycle after the command;
   // pre-filled with a non-zero pattern so zero-fill is observable
   always @(posedge i_clk) begin
      if (fillMem) begin
         for (int i = 0; i < 64; i++) begin
            memArr[i] <= 64'hA5A5_0000_0000_0000 | 64'(i);
         end
      end else if (o_mem_cen) begin
         if (o_mem_wen) begin
            memArr[o_mem_addr] <= o_mem_wdata;
         end else begin
            i_mem_rdata <= memArr[o_mem_addr];
         end
      end
   end

   task automatic applyStimulus(input logic v0, input logic we0, input logic [5:0] a0,
                                input logic [63:0] d0, input logic v1, input logic we1,
                                input logic [5:0] a1, input logic [63:0] d1);
      i_req0_valid = v0;
      i_req0_we    = we0;
      i_req0_addr  = a0;
      i_req0_wdata = d0;
      i_req1_valid = v1;
      i_req1_we    = we1;
      i_req1_addr  = a1;
      i_req1_wdata = d1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic waitPos();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
   endtask

   // Directed sequence; inputs change 1 ns after the rising edge, outputs are
   // sampled on the falling edge
   initial begin
      checks   = 0;
      failures = 0;
      acc0     = 0;
      acc1     = 0;
      fillMem  = 1'b1;
      i_rst    = 1'b1;
      applyStimulus(1'b1, 1'b0, 6'h2A, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rstReady0", 64'(o_req0_ready), 64'd0);
      checkOutput("rstRsp0V", 64'(o_rsp0_valid), 64'd0);
      checkOutput("rstRsp0D", o_rsp0_data, 64'd0);
      checkOutput("rstCen", 64'(o_mem_cen), 64'd0);
      checkOutput("rstOen", 64'(o_mem_oen), 64'd0);
      checkOutput("rstAddr", 64'(o_mem_addr), 64'd0);
      checkOutput("rstWdata", o_mem_wdata, 64'd0);
      waitPos();
      fillMem = 1'b0;
      i_rst   = 1'b0;

`ifdef SRAM_ARB_INIT_EN
      // Request held through zero-fill; pins sweep addresses 0..63
      for (int k = 0; k <= 64; k++) begin
         @(negedge i_clk);
         if (k < 64) begin
            checkOutput("initBusy", 64'(o_busy), 64'd1);
            checkOutput("initReady0", 64'(o_req0_ready), 64'd0);
            if (k >= 1) begin
               checkOutput("initCen", 64'(o_mem_cen), 64'd1);
               checkOutput("initWen", 64'(o_mem_wen), 64'd1);
               checkOutput("initAddr", 64'(o_mem_addr), 64'(k - 1));
               checkOutput("initWdata", o_mem_wdata, 64'd0);
            end
         end else begin
            checkOutput("runBusy", 64'(o_busy), 64'd0);
            checkOutput("firstGrant", 64'(o_req0_ready), 64'd1);
            checkOutput("lastInitAddr", 64'(o_mem_addr), 64'd63);
         end
         waitPos();
         if (k == 64) idle();
      end
      @(negedge i_clk);
      checkOutput("zfRdCen", 64'(o_mem_cen), 64'd1);
      checkOutput("zfRdOen", 64'(o_mem_oen), 64'd1);
      checkOutput("zfRdAddr", 64'(o_mem_addr), 64'h2A);
      waitPos();
      @(negedge i_clk);
      checkOutput("zfRsp0V", 64'(o_rsp0_valid), 64'd1);
      checkOutput("zfRsp0D", o_rsp0_data, 64'd0);
      waitPos();
`else
      idle();
      @(negedge i_clk);
      checkOutput("busyTied", 64'(o_busy), 64'd0);
      waitPos();
`endif

      // Write then read-after-write from the other requester
      applyStimulus(1'b1, 1'b1, 6'd5, DATA_A, 1'b0, 1'b0, 6'd0, 64'd0);
      @(negedge i_clk);
      checkOutput("wrReady0", 64'(o_req0_ready), 64'd1);
      checkOutput("wrReady1", 64'(o_req1_ready), 64'd0);
      waitPos();
      applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd5, 64'd0);
      @(negedge i_clk);
      checkOutput("rdReady1", 64'(o_req1_ready), 64'd1);
      checkOutput("wrPinCen", 64'(o_mem_cen), 64'd1);
      checkOutput("wrPinWen", 64'(o_mem_wen), 64'd1);
      checkOutput("wrPinOen", 64'(o_mem_oen), 64'd0);
      checkOutput("wrPinAddr", 64'(o_mem_addr), 64'd5);
      checkOutput("wrPinData", o_mem_wdata, DATA_A);
      waitPos();
      idle();
      @(negedge i_clk);
      checkOutput("rdPinWen", 64'(o_mem_wen), 64'd0);
      checkOutput("rdPinOen", 64'(o_mem_oen), 64'd1);
      checkOutput("rdPinAddr", 64'(o_mem_addr), 64'd5);
      checkOutput("rawEarly1", 64'(o_rsp1_valid), 64'd0);
      checkOutput("rawNo0a", 64'(o_rsp0_valid), 64'd0);
      waitPos();
      @(negedge i_clk);
      checkOutput("rawRsp1V", 64'(o_rsp1_valid), 64'd1);
      checkOutput("rawRsp1D", o_rsp1_data, DATA_A);
      checkOutput("rawNo0b", 64'(o_rsp0_valid), 64'd0);
      checkOutput("idleCen", 64'(o_mem_cen), 64'd0);
      waitPos();
      @(negedge i_clk);
      checkOutput("rawPulse1", 64'(o_rsp1_valid), 64'd0);
      checkOutput("rawGated1", o_rsp1_data, 64'd0);
      checkOutput("rawNo0c", 64'(o_rsp0_valid), 64'd0);
      waitPos();

      // Seed address 7 for the contention test
      applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 6'd7, DATA_B);
      @(negedge i_clk);
      checkOutput("seedReady1", 64'(o_req1_ready), 64'd1);
      waitPos();

      // Both requesters valid for six cycles: grants alternate 0,1,0,1,0,1
      applyStimulus(1'b1, 1'b0, 6'd5, 64'd0, 1'b1, 1'b0, 6'd7, 64'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk);
         if (k < 6) begin
            checkOutput($sformatf("rrReady0_%0d", k), 64'(o_req0_ready), 64'((k % 2) == 0));
            checkOutput($sformatf("rrReady1_%0d", k), 64'(o_req1_ready), 64'((k % 2) == 1));
            acc0 += int'(o_req0_ready);
            acc1 += int'(o_req1_ready);
         end
         if (k >= 2) begin
            checkOutput($sformatf("rrRsp0V_%0d", k), 64'(o_rsp0_valid), 64'((k % 2) == 0));
            checkOutput($sformatf("rrRsp1V_%0d", k), 64'(o_rsp1_valid), 64'((k % 2) == 1));
            if ((k % 2) == 0) begin
               checkOutput($sformatf("rrRsp0D_%0d", k), o_rsp0_data, DATA_A);
            end else begin
               checkOutput($sformatf("rrRsp1D_%0d", k), o_rsp1_data, DATA_B);
            end
         end
         waitPos();
         if (k == 5) idle();
      end
      checkOutput("rrAccept0", 64'(acc0), 64'd3);
      checkOutput("rrAccept1", 64'(acc1), 64'd3);

      // Lone requester 1 streams four reads with no bubble
      applyStimulus(1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd7, 64'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge i_clk);
         if (k < 4) begin
            checkOutput($sformatf("soloReady1_%0d", k), 64'(o_req1_ready), 64'd1);
            checkOutput($sformatf("soloReady0_%0d", k), 64'(o_req0_ready), 64'd0);
         end
         if (k >= 2) begin
            checkOutput($sformatf("soloRsp1V_%0d", k), 64'(o_rsp1_valid), 64'd1);
            checkOutput($sformatf("soloRsp1D_%0d", k), o_rsp1_data, DATA_B);
         end
         waitPos();
         if (k == 3) idle();
      end

      // Reset one cycle after a read is accepted: outputs clear at once and
      // the in-flight response is dropped
      applyStimulus(1'b1, 1'b0, 6'd5, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
      @(negedge i_clk);
      checkOutput("midReady0", 64'(o_req0_ready), 64'd1);
      waitPos();
      idle();
      i_rst = 1'b1;
      #1;
      checkOutput("asyncCen", 64'(o_mem_cen), 64'd0);
      checkOutput("asyncOen", 64'(o_mem_oen), 64'd0);
      checkOutput("asyncWen", 64'(o_mem_wen), 64'd0);
      checkOutput("asyncAddr", 64'(o_mem_addr), 64'd0);
      checkOutput("asyncWdata", o_mem_wdata, 64'd0);
      checkOutput("asyncRsp0V", 64'(o_rsp0_valid), 64'd0);
      checkOutput("asyncRsp1V", 64'(o_rsp1_valid), 64'd0);
      checkOutput("asyncRsp0D", o_rsp0_data, 64'd0);
      checkOutput("asyncRsp1D", o_rsp1_data, 64'd0);
      checkOutput("asyncReady0", 64'(o_req0_ready), 64'd0);
      checkOutput("asyncReady1", 64'(o_req1_ready), 64'd0);
      waitPos();
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         checkOutput($sformatf("dropRsp0_%0d", k), 64'(o_rsp0_valid), 64'd0);
         checkOutput($sformatf("dropRsp1_%0d", k), 64'(o_rsp1_valid), 64'd0);
         waitPos();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
